// File: rtl/ls7212_arbiter.sv
// Round-robin arbiter sharing one delay_timer_ls7212 among N_REQ requesters.
// Each job clears the timer, runs it through one trigger cycle and reports done/err.
//
// state  | meaning
// IDLE   | pick next requester, latch weight and mode
// LOAD   | timer held in reset
// ARM    | timer released, trigger low, wait counter loaded
// TRIG   | trigger high until delay_out_n falls
// REL    | trigger low until delay_out_n returns high
// FIN    | done pulse, grant dropped
// ABORT  | done+err pulse, timer reset
// REJECT | zero weight: grant visible one cycle, then done+err
module ls7212_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WB_W    = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*WB_W-1:0]   req_wb,
  input  logic [N_REQ*2-1:0]      req_mode,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic [N_REQ-1:0]        err,
  output logic                    busy,
  output logic [WB_W-1:0]         tmr_wb,
  output logic                    tmr_mode_a,
  output logic                    tmr_mode_b,
  output logic                    tmr_trigger,
  output logic                    tmr_reset,
  input  logic                    tmr_delay_out_n
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] PTR_RST  = IW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ARM, S_TRIG, S_REL, S_FIN, S_ABORT, S_REJECT
  } state_t;

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d, done_q, done_d, err_q, err_d;
  logic              busy_q, busy_d;
  logic [WB_W-1:0]   tmr_wb_q, tmr_wb_d;
  logic              mode_a_q, mode_a_d, mode_b_q, mode_b_d;
  logic              trig_q, trig_d, treset_q, treset_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IW-1:0]     ptr_q, ptr_d, gidx_q, gidx_d;

  logic              found;
  logic [IW-1:0]     sel;
  logic [N_REQ-1:0]  grant_sel;
  logic [WB_W-1:0]   wb_sel;
  logic [1:0]        mode_sel;
  logic              go_abort;

  // first requester at or after ptr+1, wrapping
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && req[i] && ((int'(ptr_q) + k) % N_REQ) == i) begin
          found = 1'b1;
          sel   = IW'(i);
        end
      end
    end
  end

  always_comb begin
    wb_sel    = '0;
    mode_sel  = '0;
    grant_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (sel == IW'(i)) begin
        wb_sel       = req_wb[i*WB_W +: WB_W];
        mode_sel     = req_mode[i*2 +: 2];
        grant_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    done_d   = '0;
    err_d    = '0;
    busy_d   = busy_q;
    tmr_wb_d = tmr_wb_q;
    mode_a_d = mode_a_q;
    mode_b_d = mode_b_q;
    trig_d   = trig_q;
    treset_d = treset_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    go_abort = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d   = 1'b0;
        trig_d   = 1'b0;
        treset_d = 1'b0;
        if (found) begin
          grant_d  = grant_sel;
          gidx_d   = sel;
          tmr_wb_d = wb_sel;
          mode_a_d = mode_sel[0];
          mode_b_d = mode_sel[1];
          busy_d   = 1'b1;
          if (wb_sel == '0) begin
            state_d = S_REJECT;
          end else begin
            state_d  = S_LOAD;
            treset_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        treset_d = 1'b0;
        trig_d   = 1'b0;
        state_d  = S_ARM;
      end
      S_ARM: begin
        cnt_d   = CNT_LOAD;
        trig_d  = 1'b1;
        state_d = S_TRIG;
      end
      S_TRIG: begin
        if (!tmr_delay_out_n) begin
          cnt_d   = CNT_LOAD;
          trig_d  = 1'b0;
          state_d = S_REL;
        end else if (cnt_q == '0) begin
          go_abort = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_REL: begin
        // completion is tested before the terminal count so it wins a tie
        if (tmr_delay_out_n) begin
          done_d  = grant_q;
          grant_d = '0;
          ptr_d   = gidx_q;
          state_d = S_FIN;
        end else if (cnt_q == '0) begin
          go_abort = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        busy_d   = 1'b0;
        treset_d = 1'b0;
        state_d  = S_IDLE;
      end
      S_REJECT: begin
        done_d  = grant_q;
        err_d   = grant_q;
        grant_d = '0;
        ptr_d   = gidx_q;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (go_abort) begin
      done_d   = grant_q;
      err_d    = grant_q;
      grant_d  = '0;
      ptr_d    = gidx_q;
      treset_d = 1'b1;
      trig_d   = 1'b0;
      state_d  = S_ABORT;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      busy_q   <= 1'b0;
      tmr_wb_q <= '0;
      mode_a_q <= 1'b0;
      mode_b_q <= 1'b0;
      trig_q   <= 1'b0;
      treset_q <= 1'b1;
      cnt_q    <= '0;
      ptr_q    <= PTR_RST;
      gidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      tmr_wb_q <= tmr_wb_d;
      mode_a_q <= mode_a_d;
      mode_b_q <= mode_b_d;
      trig_q   <= trig_d;
      treset_q <= treset_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gidx_q   <= gidx_d;
    end
  end

  assign grant       = grant_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = busy_q;
  assign tmr_wb      = tmr_wb_q;
  assign tmr_mode_a  = mode_a_q;
  assign tmr_mode_b  = mode_b_q;
  assign tmr_trigger = trig_q;
  assign tmr_reset   = treset_q;

endmodule

// File: doc/ls7212_arbiter.md
# ls7212_arbiter

Round-robin controller that shares one `delay_timer_ls7212` instance among `N_REQ` requesters. It latches the winner's weight and mode, then clears the timer. It then sequences the timer's trigger through one complete delay cycle, watches `delay_out_n` and returns a per-requester done/error pulse. It sits between the requester logic and the timer, and is the only block that drives the timer's `wb`, `mode_a`, `mode_b`, `trigger` and `reset`.

## Interface
- `N_REQ`, 4: number of requesters.
- `WB_W`, 8: timer weight width.
- `TIMEOUT`, 1024: maximum cycles spent in each wait state before abort; must be at least 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `req`  in  N_REQ  level request per requester.
- `req_wb`  in  N_REQ*WB_W  weight per requester; requester i uses bits [i*WB_W +: WB_W].
- `req_mode`  in  N_REQ*2  {mode_b, mode_a} per requester; requester i uses bits [i*2 +: 2].
- `grant`  out  N_REQ  one-hot; held for the whole job.
- `done`  out  N_REQ  one-cycle completion pulse to the granted requester.
- `err`  out  N_REQ  one-cycle pulse, coincident with `done`, on abort or reject.
- `busy`  out  1  high in every state except IDLE.
- `tmr_wb`  out  WB_W  weight to the timer.
- `tmr_mode_a`, `tmr_mode_b`  out  1 each  mode to the timer.
- `tmr_trigger`  out  1  trigger to the timer.
- `tmr_reset`  out  1  active-high reset to the timer.
- `tmr_delay_out_n`  in  1  timer output; same clock domain, no synchroniser.

## Operation
- All outputs are registered.
- Reset values:
  - `grant`, `done`, `err`, `busy`, `tmr_trigger`, `tmr_mode_a`, `tmr_mode_b` = 0.
  - `tmr_wb` = 0.
  - `tmr_reset` = 1.
  - Round-robin pointer = N_REQ-1, so requester 0 has first priority.
- States:
  - IDLE: if `req` != 0, select the first set bit searching from pointer+1, wrapping around. Register `grant`, `tmr_wb` and the mode bits, then go to LOAD. If the selected weight is 0, go to REJECT instead.
  - LOAD (1 cycle): `tmr_reset`=1 to clear the timer. Go to ARM.
  - ARM (1 cycle): `tmr_reset`=0, `tmr_trigger`=0 so the timer settles. Clear the wait counter. Go to TRIG.
  - TRIG: `tmr_trigger`=1.
    - If `tmr_delay_out_n`==0, clear the counter and go to REL.
    - Otherwise, if the counter equals TIMEOUT-1, go to ABORT.
    - Otherwise increment the counter.
  - REL: `tmr_trigger`=0.
    - If `tmr_delay_out_n`==1, go to FIN.
    - Otherwise, if the counter equals TIMEOUT-1, go to ABORT.
    - Otherwise increment the counter.
  - FIN (1 cycle): `done[g]`=1, `grant` cleared, pointer set to g. Go to IDLE.
  - ABORT (1 cycle): `done[g]`=`err[g]`=1, `tmr_reset`=1, `tmr_trigger`=0, `grant` cleared, pointer set to g. Go to IDLE.
  - REJECT (1 cycle): `done[g]`=`err[g]`=1, `grant` cleared, pointer set to g, no timer activity. Go to IDLE.
- `tmr_wb` and the mode outputs hold the last job's values until the next grant.
- `req`, `req_wb` and `req_mode` are sampled only in IDLE. Changes, including `req` dropping, during a job are ignored; the job runs to FIN or ABORT.
- Wait counter width is clog2(TIMEOUT).

## Timing
- Grant latency: `req` is seen in IDLE at cycle 0 → `grant`, `busy` high and state LOAD from cycle 1; `tmr_reset` pulses in cycle 1; `tmr_trigger` rises in cycle 3.
- The completion condition takes priority over timeout when both occur in the same cycle.
- `done` is high in the same cycle that `grant` falls. The next grant comes at the earliest 2 cycles after `done`: FIN, then IDLE, then the grant.
- A requester that keeps `req` high after `done` rotates behind the other active requesters.
- Worst-case job length is 2*TIMEOUT + 5 cycles.
- `reset_n` low in any state: at the next edge, all outputs take their reset values and the state returns to IDLE. No `done` is issued for the killed job.

## Test plan
- Single requester: req=4'b0001, wb=10, mode=00, driving a real `delay_timer_ls7212` → `grant`=0001 at cycle 1 and `tmr_reset` pulse at cycle 1. `tmr_trigger` is held until `delay_out_n` falls, then released. `done[0]`=1, `err`=0 once `delay_out_n` returns high.
- Round robin: req=4'b1111 held, all wb=3 → grant order 0,1,2,3,0. Then assert req=4'b1001 after requester 0 completes → next grant is 3.
- Timeout: `tmr_delay_out_n` stuck at 1 → `done[g]`=`err[g]`=1 exactly TIMEOUT cycles after entering TRIG, with `tmr_reset`=1 in that cycle.
- Reject: req=4'b0100 with wb=0 → `grant`=0100 for one cycle, then `done[2]`=`err[2]`=1. `tmr_trigger` never rises.
- Reset mid-job: drop `reset_n` for 1 cycle while in TRIG → next cycle `grant`=0, `tmr_trigger`=0, `tmr_reset`=1, no `done`. With req still high after `reset_n` rises, requester 0 is granted first.
- Simultaneous events: in the cycle TRIG reaches TIMEOUT-1, drive `delay_out_n`=0 → transition to REL with no `err`.
